// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if: output word handshake of the serial frame receiver.
//   data_out : received word, first serial bit at bit 0
//   valid    : data_out holds an unconsumed word
//   ready    : consumer takes data_out when valid && ready
// Modports: master = receiver side (drives data_out/valid), slave = consumer side.
interface serial_frame_receiver_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              ready;

  modport master (output data_out, output valid, input ready);
  modport slave  (input data_out, input valid, output ready);
endinterface

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: detects a start bit, shifts in DATA_W bits LSB-first (one per clock),
// checks the stop bit and offers the word through a one-word valid/ready output register.
// Optional feature macro: SERIAL_RX_PARITY_EN adds an even-parity bit after the data bits.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   serI       : serial line, idle high
//   out        : serial_frame_receiver_if.master (data_out, valid, ready)
//   busy       : high whenever the receiver is not idle
//   frame_err  : one-cycle pulse, stop bit sampled as 0
//   parity_err : one-cycle pulse, parity mismatch (0 without SERIAL_RX_PARITY_EN)
//   overrun    : one-cycle pulse, completed word dropped because the output was full
module serial_frame_receiver #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           serI,
  serial_frame_receiver_if.master        out,
  output logic                           busy,
  output logic                           frame_err,
  output logic                           parity_err,
  output logic                           overrun
);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              complete;
  logic              mismatch;

`ifdef SERIAL_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign mismatch   = ^{sh_q, par_q};
  assign parity_err = parity_err_q;
`else
  assign mismatch   = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (!serI) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        sh_d = {serI, sh_q[DATA_W-1:1]};
        if (cnt_q == LastBit) begin
`ifdef SERIAL_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      StParity: begin
        par_d   = serI;
        state_d = StStop;
      end
`endif
      StStop: begin
        state_d     = StIdle;
        frame_err_d = !serI;
`ifdef SERIAL_RX_PARITY_EN
        parity_err_d = mismatch;
`endif
        complete    = serI && !mismatch;
      end
      default: state_d = StIdle;
    endcase

    // A consume in the completing cycle frees the register for the new word.
    if (complete) begin
      if (!valid_q || out.ready) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out.ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out.data_out = data_q;
  assign out.valid    = valid_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed frames against a frame-level model of the receiver.
// Build with SERIAL_RX_PARITY_EN to exercise the parity variant (DATA_W = 5).
module tb_serial_frame_receiver;

`ifdef SERIAL_RX_PARITY_EN
  localparam int unsigned DATA_W = 5;
`else
  localparam int unsigned DATA_W = 8;
`endif

  localparam int KNone  = 0;
  localparam int KStart = 1;
  localparam int KMid   = 2;
  localparam int KStop  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serI = 1'b1;
  logic busy, frame_err, parity_err, overrun;

  serial_frame_receiver_if #(.DATA_W(DATA_W)) rx_if ();

  serial_frame_receiver #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .serI       (serI),
    .out        (rx_if),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Frame-level model of the visible outputs.
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_busy, m_frame_err, m_parity_err, m_overrun;
  logic              chk_en = 1'b0;

  int vectors = 0;
  int errors  = 0;
  int busy_run = 0;
  int last_busy_len = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out", 32'(rx_if.data_out), 32'(m_data));
      check("valid", 32'(rx_if.valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_busy));
      check("frame_err", 32'(frame_err), 32'(m_frame_err));
      check("parity_err", 32'(parity_err), 32'(m_parity_err));
      check("overrun", 32'(overrun), 32'(m_overrun));
      if (busy === 1'b1) begin
        busy_run++;
      end else begin
        if (busy_run != 0) last_busy_len = busy_run;
        busy_run = 0;
      end
    end
  end

  // One clock edge; 'kind' says what this edge means for the frame being sent.
  task automatic step(input logic s, input logic r, input int kind,
                      input logic [DATA_W-1:0] word, input logic ferr, input logic perr);
    logic hs, done;
    serI = s;
    rx_if.ready = r;
    @(posedge clk);
    hs = m_valid && r;
    done = (kind == KStop) && !ferr && !perr;
    m_frame_err  = (kind == KStop) && ferr;
    m_parity_err = (kind == KStop) && perr;
    m_overrun    = 1'b0;
    if (kind == KStart) m_busy = 1'b1;
    else if (kind == KStop) m_busy = 1'b0;
    if (done) begin
      if (!m_valid || r) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end else if (hs) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, r, KNone, '0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] word, input logic stop, input logic par,
                            input logic r_body, input logic r_stop);
    logic perr;
`ifdef SERIAL_RX_PARITY_EN
    perr = ^{word, par};
`else
    perr = 1'b0;
`endif
    step(1'b0, r_body, KStart, word, 1'b0, 1'b0);
    for (int i = 0; i < int'(DATA_W); i++) step(word[i], r_body, KMid, word, 1'b0, 1'b0);
`ifdef SERIAL_RX_PARITY_EN
    step(par, r_body, KMid, word, 1'b0, 1'b0);
`endif
    step(stop, r_stop, KStop, word, !stop, perr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    m_data = '0; m_valid = 1'b0; m_busy = 1'b0;
    m_frame_err = 1'b0; m_parity_err = 1'b0; m_overrun = 1'b0;
    chk_en = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rx_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    idle(2, 1'b1);

`ifdef SERIAL_RX_PARITY_EN
    // 5'b10110 has three ones; parity 1 makes the total even.
    send_frame(5'b10110, 1'b1, 1'b1, 1'b1, 1'b1);
    check("par_ok_valid", 32'(rx_if.valid), 32'd1);
    check("par_ok_data", 32'(rx_if.data_out), 32'h16);
    check("par_ok_perr", 32'(parity_err), 32'd0);
    idle(1, 1'b1);
    check("par_ok_drain", 32'(rx_if.valid), 32'd0);
    send_frame(5'b10110, 1'b1, 1'b0, 1'b1, 1'b1);
    check("par_bad_perr", 32'(parity_err), 32'd1);
    check("par_bad_valid", 32'(rx_if.valid), 32'd0);
    check("par_bad_ferr", 32'(frame_err), 32'd0);
    send_frame(5'b00000, 1'b0, 1'b1, 1'b1, 1'b1);
    check("both_perr", 32'(parity_err), 32'd1);
    check("both_ferr", 32'(frame_err), 32'd1);
    send_frame(5'b11111, 1'b1, 1'b1, 1'b1, 1'b1);
    check("par_b2b_data", 32'(rx_if.data_out), 32'h1F);
    idle(2, 1'b1);
    step(1'b0, 1'b1, KStart, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, KMid, '0, 1'b0, 1'b0);
    do_reset();
    check("par_rst_busy", 32'(busy), 32'd0);
    send_frame(5'b01001, 1'b1, 1'b0, 1'b1, 1'b1);
    check("par_after_rst", 32'(rx_if.data_out), 32'h09);
    idle(2, 1'b1);
`else
    // Single frame, bits 1,0,1,0,0,1,0,1 LSB first.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    check("a5_data", 32'(rx_if.data_out), 32'hA5);
    check("a5_valid", 32'(rx_if.valid), 32'd1);
    check("a5_model", 32'(m_data), 32'hA5);
    idle(1, 1'b1);
    check("a5_drain", 32'(rx_if.valid), 32'd0);
    check("a5_busy_len", 32'(last_busy_len), 32'd9);
    idle(1, 1'b1);

    // Framing error then an immediate follow-up frame.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ferr_pulse", 32'(frame_err), 32'd1);
    check("ferr_valid", 32'(rx_if.valid), 32'd0);
    check("ferr_busy", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
    check("after_ferr_data", 32'(rx_if.data_out), 32'h81);
    check("after_ferr_ferr", 32'(frame_err), 32'd0);
    idle(2, 1'b1);

    // Backpressure and overrun.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_data", 32'(rx_if.data_out), 32'h11);
    check("ovr_valid", 32'(rx_if.valid), 32'd1);
    idle(1, 1'b1);
    check("ovr_drain", 32'(rx_if.valid), 32'd0);
    idle(1, 1'b0);

    // Consume and complete on the same edge.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    check("simul_data", 32'(rx_if.data_out), 32'h22);
    check("simul_valid", 32'(rx_if.valid), 32'd1);
    check("simul_ovr", 32'(overrun), 32'd0);
    idle(2, 1'b1);

    // Reset after four data bits.
    step(1'b0, 1'b1, KStart, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, KMid, '0, 1'b0, 1'b0);
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(rx_if.data_out), 32'd0);
    send_frame(8'hF0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("after_rst_data", 32'(rx_if.data_out), 32'hF0);

    // Back-to-back frames with ready held high.
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
    check("b2b_data", 32'(rx_if.data_out), 32'h5A);
    idle(3, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
